// File: rtl/booth_mult_ctrl.sv
// booth_mult_ctrl
// Sequential signed 32x32 radix-2 Booth multiplier controller for the multdiv
// unit. One Booth iteration per clock over 32 iterations, sharing a single
// 33-bit add/subtract path built from four 8-bit carry-lookahead groups plus
// a 1-bit top slice.
//
// Ports:
//   clock          in   1  rising-edge clock
//   reset          in   1  synchronous, active-high, highest priority
//   ctrl_MULT      in   1  start pulse; operands sampled on the same edge
//   data_operandA  in  32  multiplicand (two's complement)
//   data_operandB  in  32  multiplier (two's complement)
//   data_result    out 32  low 32 bits of the product (held until next result)
//   data_exception out  1  product does not fit in signed 32 bits
//   data_resultRDY out  1  one-cycle pulse when result/exception are fresh
module booth_mult_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [32:0] m;
  // Booth register layout: {U[32:0], L[31:0], q}
  logic [65:0] p;
  logic [4:0]  cnt;

  logic [32:0] u;
  logic [1:0]  booth_sel;
  logic        sub;
  logic [32:0] add_b;
  logic [32:0] sum;
  logic        carry;
  logic        c_int;
  logic        grp_g;
  logic        grp_p;
  logic        bit_g;
  logic        bit_p;
  logic [32:0] u_new;
  logic [65:0] p_next;
  logic [32:0] sign_bits;
  logic        exc_next;

  assign u         = p[65:33];
  assign booth_sel = {p[1], p[0]};

  // Shared 33-bit adder. Each 8-bit group produces its own sums and a group
  // generate/propagate pair; the carry into the next group comes from those
  // G/P terms. Subtraction is U + ~M with carry-in 1. The final carry-out is
  // dropped: with a 33-bit U the M = -2^31 case cannot overflow.
  always_comb begin
    sub   = (booth_sel == 2'b10);
    add_b = sub ? ~m : m;
    carry = sub;
    sum   = '0;
    c_int = 1'b0;
    grp_g = 1'b0;
    grp_p = 1'b1;
    bit_g = 1'b0;
    bit_p = 1'b0;
    for (int g = 0; g < 4; g++) begin
      c_int = carry;
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int i = 0; i < 8; i++) begin
        bit_g        = u[g*8+i] & add_b[g*8+i];
        bit_p        = u[g*8+i] ^ add_b[g*8+i];
        sum[g*8+i]   = bit_p ^ c_int;
        c_int        = bit_g | (bit_p & c_int);
        grp_g        = bit_g | (bit_p & grp_g);
        grp_p        = grp_p & bit_p;
      end
      carry = grp_g | (grp_p & carry);
    end
    sum[32] = u[32] ^ add_b[32] ^ carry;
  end

  // Booth step: 01 adds M, 10 subtracts M, 00/11 keep U; then arithmetic
  // shift right of the whole {U, L, q} register by one.
  always_comb begin
    u_new  = ((booth_sel == 2'b01) || (booth_sel == 2'b10)) ? sum : u;
    p_next = {u_new[32], u_new, p[32:1]};
  end

  // Product is {U[31:0], L}; it fits in 32 signed bits only when bits 63..31
  // are all equal.
  assign sign_bits = {p_next[64:33], p_next[32]};
  assign exc_next  = ~((&sign_bits) | (~|sign_bits));

  // Control FSM with registered outputs. A start pulse wins over everything
  // except reset, including the edge that would otherwise finish the op.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      m              <= '0;
      p              <= '0;
      cnt            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_MULT) begin
        m     <= {data_operandA[31], data_operandA};
        p     <= {33'd0, data_operandB, 1'b0};
        cnt   <= '0;
        state <= RUN;
      end else begin
        case (state)
          RUN: begin
            p   <= p_next;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state          <= DONE;
              data_result    <= p_next[32:1];
              data_exception <= exc_next;
              data_resultRDY <= 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// tb_booth_mult_ctrl
// Directed self-checking bench for booth_mult_ctrl. Expected products are
// hand-computed constants.
module tb_booth_mult_ctrl;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int compareCount;
  int mismatchCount;

  booth_mult_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  // 10 ns clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Single comparison point: counts and reports
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Present operands with a one-cycle start pulse; returns #1 after the start edge
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
  endtask

  // Advance n edges, returning how many of them showed RDY high
  task automatic waitEdges(input int n, output int rdyCount);
    rdyCount = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) rdyCount++;
    end
  endtask

  // Following a start edge: RDY must stay low for edges 1..31, be high after
  // edge 32 with the expected outputs, and drop after edge 33.
  task automatic runAndCheck(input string tag, input logic [31:0] expRes,
                             input logic expExc);
    int early;
    waitEdges(31, early);
    checkOutput({tag, "_early_rdy"}, early, 0);
    @(posedge clock);
    #1;
    checkOutput({tag, "_rdy"}, {31'd0, data_resultRDY}, 32'd1);
    checkOutput({tag, "_result"}, data_result, expRes);
    checkOutput({tag, "_exception"}, {31'd0, data_exception}, {31'd0, expExc});
    @(posedge clock);
    #1;
    checkOutput({tag, "_rdy_drop"}, {31'd0, data_resultRDY}, 32'd0);
  endtask

  initial begin
    int cnt;
    compareCount  = 0;
    mismatchCount = 0;
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;

    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("reset_result", data_result, 32'd0);
    checkOutput("reset_exception", {31'd0, data_exception}, 32'd0);
    checkOutput("reset_rdy", {31'd0, data_resultRDY}, 32'd0);

    applyStimulus(32'd3, 32'd5);
    runAndCheck("3x5", 32'd15, 1'b0);

    applyStimulus(32'hFFFFFFF9, 32'd6);
    runAndCheck("m7x6", 32'hFFFFFFD6, 1'b0);

    applyStimulus(32'h80000000, 32'hFFFFFFFF);
    runAndCheck("minxm1", 32'h80000000, 1'b1);

    applyStimulus(32'h80000000, 32'd1);
    runAndCheck("minx1", 32'h80000000, 1'b0);

    applyStimulus(32'h00010000, 32'h00010000);
    runAndCheck("2p16sq", 32'h00000000, 1'b1);

    // Outputs hold while idle
    waitEdges(5, cnt);
    checkOutput("hold_rdy_count", cnt, 0);
    checkOutput("hold_exception", {31'd0, data_exception}, 32'd1);

    // Restart mid-operation at cycle 10
    applyStimulus(32'd12, 32'd12);
    waitEdges(9, cnt);
    checkOutput("restart_first_rdy", cnt, 0);
    checkOutput("restart_hold_exc", {31'd0, data_exception}, 32'd1);
    applyStimulus(32'd4, 32'hFFFFFFFD);
    runAndCheck("4xm3", 32'hFFFFFFF4, 1'b0);

    // Reset at cycle 20, with a simultaneous (ignored) start
    applyStimulus(32'd100, 32'd100);
    waitEdges(19, cnt);
    checkOutput("prereset_rdy", cnt, 0);
    reset         = 1'b1;
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd5;
    data_operandB = 32'd5;
    @(posedge clock);
    #1;
    reset     = 1'b0;
    ctrl_MULT = 1'b0;
    checkOutput("midreset_result", data_result, 32'd0);
    checkOutput("midreset_exception", {31'd0, data_exception}, 32'd0);
    waitEdges(40, cnt);
    checkOutput("postreset_rdy_count", cnt, 0);
    checkOutput("postreset_result", data_result, 32'd0);

    // Back-to-back: start 7x7 in the DONE cycle of 2x9
    applyStimulus(32'd2, 32'd9);
    waitEdges(31, cnt);
    checkOutput("b2b_early_rdy", cnt, 0);
    @(posedge clock);
    #1;
    checkOutput("b2b_rdy1", {31'd0, data_resultRDY}, 32'd1);
    checkOutput("b2b_result1", data_result, 32'd18);
    applyStimulus(32'd7, 32'd7);
    checkOutput("b2b_rdy1_drop", {31'd0, data_resultRDY}, 32'd0);
    runAndCheck("b2b_7x7", 32'd49, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
